// File: rtl/scope_acq_pkg.sv
// Shared types for the digitizer acquisition sequencer: the state encoding
// reported on the state port, and the default buffer geometry.
package scope_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } acq_state_t;

  localparam int BUF_AW_DEFAULT = 13;
  localparam int DEPTH = 2 ** BUF_AW_DEFAULT;

endpackage

// File: rtl/scope_acq_seq.sv
// Acquisition sequencer: arm / pretrigger fill / trigger wait / post-trigger / done,
// generating the circular-buffer write strobe and address one cycle after each sample.
module scope_acq_seq
  import scope_acq_pkg::*;
#(
  parameter int BUF_AW = 13,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              auto_rearm,
  input  logic [BUF_AW-1:0] pretrig,
  input  logic              sample_valid,
  input  logic              trig_in,
  input  logic              rd_ack,
  output logic              wr_en,
  output logic [BUF_AW-1:0] wr_addr,
  output logic [BUF_AW-1:0] trig_addr,
  output logic [BUF_AW-1:0] start_addr,
  output logic [2:0]        state,
  output logic              done,
  output logic [CNT_W-1:0]  acq_count
);

  localparam logic [BUF_AW-1:0] ADDR_ONE = BUF_AW'(1);

  acq_state_t        st_reg, st_next;
  logic [BUF_AW-1:0] ptr_reg;
  logic [BUF_AW-1:0] cnt_reg;   // PRE: writes so far; POST: writes remaining
  logic [BUF_AW-1:0] pre_reg;
  logic              accept;
  logic              relatch;
  logic              trig_hit;
  logic              post_zero;

  // Post-trigger length is DEPTH-1-pre, i.e. the bitwise complement of pre.
  assign post_zero = &pre_reg;
  assign state     = st_reg;

  always_comb begin
    st_next  = st_reg;
    relatch  = 1'b0;
    trig_hit = 1'b0;
    accept   = sample_valid && !abort &&
               (st_reg == ST_PRE || st_reg == ST_ARMED || st_reg == ST_POST);
    if (abort) begin
      st_next = ST_IDLE;
    end else begin
      case (st_reg)
        ST_IDLE:  if (arm) relatch = 1'b1;
        ST_PRE:   if (sample_valid && (cnt_reg + ADDR_ONE) == pre_reg) st_next = ST_ARMED;
        ST_ARMED: if (sample_valid && trig_in) begin
                    trig_hit = 1'b1;
                    st_next  = post_zero ? ST_DONE : ST_POST;
                  end
        ST_POST:  if (sample_valid && cnt_reg == ADDR_ONE) st_next = ST_DONE;
        ST_DONE:  if (arm || (rd_ack && auto_rearm)) relatch = 1'b1;
                  else if (rd_ack) st_next = ST_IDLE;
        default:  st_next = ST_IDLE;
      endcase
      if (relatch) st_next = (pretrig == '0) ? ST_ARMED : ST_PRE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg     <= ST_IDLE;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      pre_reg    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      done       <= 1'b0;
      acq_count  <= '0;
    end else begin
      st_reg <= st_next;
      wr_en  <= accept;
      done   <= (st_next == ST_DONE);
      if (accept) begin
        wr_addr <= ptr_reg;
        ptr_reg <= ptr_reg + ADDR_ONE;
      end
      if (accept && st_reg == ST_PRE)  cnt_reg <= cnt_reg + ADDR_ONE;
      if (accept && st_reg == ST_POST) cnt_reg <= cnt_reg - ADDR_ONE;
      if (trig_hit) begin
        trig_addr  <= ptr_reg;
        start_addr <= ptr_reg - pre_reg;
        cnt_reg    <= ~pre_reg;
      end
      if (relatch) begin
        pre_reg <= pretrig;
        ptr_reg <= '0;
        cnt_reg <= '0;
      end
      if (st_next == ST_DONE && st_reg != ST_DONE) acq_count <= acq_count + CNT_W'(1);
    end
  end

endmodule
